// File: rtl/dest_reg_pipe.sv
// rtl/dest_reg_pipe.sv - write-back destination resolver, DEPTH-stage dest pipe and RAW scoreboard
module dest_reg_pipe #(
    parameter int REG_W    = 5,
    parameter int LINK_REG = 31,
    parameter int DEPTH    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       sel_dest,
    input  logic             reg_write,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic             stall,
    input  logic             flush,
    input  logic [REG_W-1:0] src_a,
    input  logic [REG_W-1:0] src_b,
    output logic [REG_W-1:0] dest_d,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [REG_W-1:0] wb_dest,
    output logic             hazard_a,
    output logic             hazard_b,
    output logic [DEPTH-1:0] hit_a,
    output logic [DEPTH-1:0] hit_b
);

    localparam logic [REG_W-1:0] LINK_IDX = REG_W'(LINK_REG);

    // Per-stage state; index 0 is the stage fed by decode
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] we_q;
    logic [REG_W-1:0] dest_q [DEPTH];

    logic             entry_we_d;

    // Resolve destination index and whether it is a real register-file write
    always_comb begin
        dest_d = '0;
        case (sel_dest)
            2'b00:   dest_d = rt;
            2'b01:   dest_d = rd;
            2'b10:   dest_d = LINK_IDX;
            default: dest_d = '0;
        endcase
        // Register 0 is hardwired, so a write to it is dropped here rather than at write-back
        entry_we_d = in_valid & reg_write & (sel_dest != 2'b11) & (dest_d != '0);
    end

    // Shift pipe: flush bubbles stage 0 even under stall, older stages obey stall only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            we_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                valid_q[0] <= 1'b0;
                we_q[0]    <= 1'b0;
                dest_q[0]  <= '0;
            end else if (!stall) begin
                valid_q[0] <= in_valid;
                we_q[0]    <= entry_we_d;
                dest_q[0]  <= dest_d;
            end
            if (!stall) begin
                for (int i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    we_q[i]    <= we_q[i-1];
                    dest_q[i]  <= dest_q[i-1];
                end
            end
        end
    end

    assign wb_valid = valid_q[DEPTH-1];
    assign wb_we    = we_q[DEPTH-1];
    assign wb_dest  = dest_q[DEPTH-1];

    // Scoreboard: scan oldest to youngest so the youngest matching stage is the one left set
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && we_q[i] && (dest_q[i] == src_a) && (src_a != '0)) begin
                hit_a    = '0;
                hit_a[i] = 1'b1;
            end
            if (valid_q[i] && we_q[i] && (dest_q[i] == src_b) && (src_b != '0)) begin
                hit_b    = '0;
                hit_b[i] = 1'b1;
            end
        end
    end

    assign hazard_a = |hit_a;
    assign hazard_b = |hit_b;

endmodule

// File: tb/tb_dest_reg_pipe.sv
// tb/tb_dest_reg_pipe.sv - directed self-checking bench for dest_reg_pipe
module tb_dest_reg_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] sel_dest;
    logic       reg_write;
    logic [4:0] rt, rd;
    logic       stall, flush;
    logic [4:0] src_a, src_b;
    logic [4:0] dest_d;
    logic       wb_valid, wb_we;
    logic [4:0] wb_dest;
    logic       hazard_a, hazard_b;
    logic [2:0] hit_a, hit_b;

    int vectors = 0;
    int miscompares = 0;

    dest_reg_pipe #(.REG_W(5), .LINK_REG(31), .DEPTH(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sel_dest(sel_dest),
        .reg_write(reg_write), .rt(rt), .rd(rd), .stall(stall), .flush(flush),
        .src_a(src_a), .src_b(src_b), .dest_d(dest_d), .wb_valid(wb_valid),
        .wb_we(wb_we), .wb_dest(wb_dest), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .hit_a(hit_a), .hit_b(hit_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic rw,
                         input logic [4:0] rt_v, input logic [4:0] rd_v);
        in_valid  = v;
        sel_dest  = sel;
        reg_write = rw;
        rt        = rt_v;
        rd        = rd_v;
    endtask

    task automatic idle();
        drive(1'b0, 2'b11, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        src_a = 5'd0;
        src_b = 5'd0;
        idle();
        tick();
        tick();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_dest", wb_dest, 0);
        chk("rst_hazard_a", hazard_a, 0);
        chk("rst_hit_b", hit_b, 0);
        reset = 1'b0;

        // Destination mux
        drive(1'b1, 2'b00, 1'b1, 5'd5, 5'd7); #1;
        chk("mux_rt", dest_d, 5);
        drive(1'b1, 2'b01, 1'b1, 5'd5, 5'd7); #1;
        chk("mux_rd", dest_d, 7);
        drive(1'b1, 2'b11, 1'b1, 5'd5, 5'd7); #1;
        chk("mux_nowrite", dest_d, 0);
        idle();
        tick(); tick(); tick();

        // Link destination reaches write-back two edges after acceptance
        drive(1'b1, 2'b10, 1'b1, 5'd5, 5'd7); #1;
        chk("link_dest_d", dest_d, 31);
        tick();
        idle();
        chk("link_e1_we", wb_we, 0);
        tick();
        chk("link_e2_we", wb_we, 0);
        tick();
        chk("link_wb_valid", wb_valid, 1);
        chk("link_wb_we", wb_we, 1);
        chk("link_wb_dest", wb_dest, 31);
        src_a = 5'd31; #1;
        chk("link_hit_a", hit_a, 3'b100);
        tick();
        chk("link_drain_valid", wb_valid, 0);
        chk("link_drain_hazard", hazard_a, 0);

        // Back-to-back writes to r8: youngest stage wins
        src_a = 5'd8;
        drive(1'b1, 2'b00, 1'b1, 5'd8, 5'd0);
        tick();
        chk("raw_hit1", hit_a, 3'b001);
        chk("raw_haz1", hazard_a, 1);
        tick();
        idle();
        chk("raw_hit2", hit_a, 3'b001);
        tick();
        chk("raw_hit3", hit_a, 3'b010);
        tick();
        chk("raw_hit4", hit_a, 3'b100);
        chk("raw_haz4", hazard_a, 1);
        tick();
        chk("raw_hit5", hit_a, 3'b000);
        chk("raw_haz5", hazard_a, 0);

        // Write to r0 is never a write
        src_a = 5'd0;
        drive(1'b1, 2'b01, 1'b1, 5'd3, 5'd0);
        tick();
        idle();
        chk("r0_hazard", hazard_a, 0);
        tick(); tick();
        chk("r0_wb_valid", wb_valid, 1);
        chk("r0_wb_we", wb_we, 0);

        // Stall with three live entries
        drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd10); tick();
        drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd11); tick();
        drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd12); tick();
        chk("stl_pre_dest", wb_dest, 10);
        stall = 1'b1;
        drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd13);
        src_a = 5'd12;
        src_b = 5'd10;
        tick();
        chk("stl1_dest", wb_dest, 10);
        chk("stl1_hit_a", hit_a, 3'b001);
        chk("stl1_hit_b", hit_b, 3'b100);
        tick();
        chk("stl2_dest", wb_dest, 10);
        chk("stl2_hit_a", hit_a, 3'b001);
        chk("stl2_hit_b", hit_b, 3'b100);
        stall = 1'b0;
        idle();
        tick();
        chk("stl_res1_dest", wb_dest, 11);
        chk("stl_res1_hit_a", hit_a, 3'b010);
        chk("stl_res1_hit_b", hit_b, 3'b000);
        tick();
        chk("stl_res2_dest", wb_dest, 12);

        // Flush under stall: stage 0 bubbles, older stages hold
        drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd20); tick();
        drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd21); tick();
        drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd22); tick();
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd9);
        src_a = 5'd9;
        src_b = 5'd22;
        tick();
        chk("fl_haz_9", hazard_a, 0);
        chk("fl_hit_22", hit_b, 3'b000);
        chk("fl_wb_dest", wb_dest, 20);
        src_a = 5'd21; #1;
        chk("fl_hit_21", hit_a, 3'b010);
        stall = 1'b0;
        flush = 1'b0;
        idle();
        tick(); tick(); tick();

        // Asynchronous reset between edges while stalled
        src_a = 5'd14;
        drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd14);
        tick();
        idle();
        tick(); tick();
        chk("ar_pre_dest", wb_dest, 14);
        chk("ar_pre_hit", hit_a, 3'b100);
        stall = 1'b1;
        drive(1'b1, 2'b00, 1'b1, 5'd17, 5'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_wb_valid", wb_valid, 0);
        chk("ar_wb_we", wb_we, 0);
        chk("ar_wb_dest", wb_dest, 0);
        chk("ar_hazard_a", hazard_a, 0);
        chk("ar_hit_a", hit_a, 0);
        chk("ar_dest_d", dest_d, 17);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        src_a = 5'd15;
        drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd15);
        tick();
        idle();
        chk("post_e1_valid", wb_valid, 0);
        chk("post_e1_hit", hit_a, 3'b001);
        tick();
        chk("post_e2_valid", wb_valid, 0);
        tick();
        chk("post_wb_valid", wb_valid, 1);
        chk("post_wb_we", wb_we, 1);
        chk("post_wb_dest", wb_dest, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
